// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch state encoding, IF/ID payload.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_id_reg.sv
// Generic stage register: kill beats load, otherwise holds. Kill clears only
// valid and instr so the PC fields stay around for debug visibility.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   kill_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
    end else if (kill_i) begin
      q_q.valid <= 1'b0;
      q_q.instr <= NOP_INSTR;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem fetch FSM, and the
// IF/ID register. Flush redirects the PC and kills both IF/ID and any fetch in flight.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  next_pc,
  input  logic         flush,
  input  logic         stall,
  output logic [31:0]  pc4,
  fetch_unit_if.master imem,
  output logic         if_id_valid,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_pc4,
  output logic [31:0]  if_id_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         ld, kill;
  if_id_t       ld_data, if_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    ld      = 1'b0;
    kill    = 1'b0;
    ld_data = '{valid: 1'b1, pc: pc_q, pc4: pc4, instr: imem.imem_rsp_data};

    if (flush) begin
      pc_d   = next_pc;
      kill   = 1'b1;
      hold_d = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        // A handshake accepted alongside a flush still produces a response to drop.
        if (flush)                    state_d = imem.imem_req_ready ? S_DROP : S_REQ;
        else if (imem.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = imem.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem.imem_rsp_valid) begin
          if (!stall) begin
            ld      = 1'b1;
            pc_d    = next_pc;
            state_d = S_REQ;
          end else begin
            hold_d  = imem.imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (!stall) begin
          ld            = 1'b1;
          ld_data.instr = hold_q;
          pc_d          = next_pc;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (!flush && imem.imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem.imem_req_valid = (state_q == S_REQ);
  assign imem.imem_addr      = pc_q;
  assign pc4                 = pc_plus4(pc_q);

  if_id_reg u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .kill_i (kill),
    .d_i    (ld_data),
    .q_o    (if_id_q)
  );

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (fetch address stream + queue of undelivered fetches).
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, stall;
  logic [31:0] target, next_pc, pc4;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;

  logic [31:0] w_pc4, w_next_pc;
  logic        w_valid;
  logic [31:0] w_pc, w_pc_4, w_instr;

  fetch_unit_if mif ();
  fetch_unit_if wif ();

  assign next_pc   = flush ? target : pc4;
  assign w_next_pc = w_pc4;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .flush(flush), .stall(stall),
    .pc4(pc4), .imem(mif.master), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .next_pc(w_next_pc), .flush(1'b0), .stall(1'b0),
    .pc4(w_pc4), .imem(wif.master), .if_id_valid(w_valid), .if_id_pc(w_pc),
    .if_id_pc4(w_pc_4), .if_id_instr(w_instr)
  );

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] pend_q[$];
  bit          mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_lat = 0;
  bit          lat_rand = 1'b0;
  bit          directed = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (directed) return (a == 32'd12) ? 32'h0000_DEAD : ((a >> 2) + 32'd1) * 32'd17;
    return 32'h8000_0000 | (a ^ 32'h1357_9BDF);
  endfunction

  // One clock: memory drives its response, then the model checks the edge's effect.
  task automatic tick();
    logic        hs, rsp, fl, st, rs, b_valid;
    logic [31:0] hs_addr, tgt, b_pc, b_pc4, b_instr, ep;
    rsp = mem_pend && (mem_wait == 0);
    mif.imem_rsp_valid = rsp;
    mif.imem_rsp_data  = rsp ? mem_word(mem_addr) : 32'h0;
    hs = mif.imem_req_valid && mif.imem_req_ready;
    hs_addr = mif.imem_addr;
    fl = flush; st = stall; rs = rst; tgt = target;
    b_valid = if_id_valid; b_pc = if_id_pc; b_pc4 = if_id_pc4; b_instr = if_id_instr;
    @(posedge clk);
    @(negedge clk);
    if (rs) begin
      pend_q.delete(); mem_pend = 1'b0; mem_wait = 0; exp_fetch = 32'h0;
      return;
    end
    if (rsp) mem_pend = 1'b0;
    if (hs) begin
      total++;
      if (hs_addr !== exp_fetch) begin
        bad++; $display("FAIL req_addr: got %h want %h", hs_addr, exp_fetch);
      end
      total++;
      if (mem_pend) begin
        bad++; $display("FAIL outstanding: got 2 in flight want 1");
      end
      mem_pend = 1'b1;
      mem_wait = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
      mem_addr = hs_addr;
    end else if (mem_pend) begin
      mem_wait--;
    end
    if (fl) begin
      pend_q.delete();
      exp_fetch = tgt;
      total++;
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
        bad++; $display("FAIL kill: got v=%0b instr=%h want v=0 instr=%h", if_id_valid, if_id_instr, NOP_INSTR);
      end
    end else begin
      if (hs) begin
        pend_q.push_back(hs_addr);
        exp_fetch = hs_addr + 32'd4;
      end
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {b_valid, b_pc, b_pc4, b_instr}) begin
        total++;
        if (st || pend_q.size() == 0) begin
          bad++; $display("FAIL if_id_hold: got update pc=%h stall=%0b want no change", if_id_pc, st);
        end else begin
          ep = pend_q.pop_front();
          delivered++;
          total++;
          if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, ep, ep + 32'd4, mem_word(ep)}) begin
            bad++; $display("FAIL deliver: got v=%0b pc=%h pc4=%h instr=%h want pc=%h instr=%h",
                            if_id_valid, if_id_pc, if_id_pc4, if_id_instr, ep, mem_word(ep));
          end
        end
      end
    end
    total++;
    if (mif.imem_req_valid !== (!mem_pend && pend_q.size() == 0)) begin
      bad++; $display("FAIL req_valid: got %0b want %0b", mif.imem_req_valid, !mem_pend && pend_q.size() == 0);
    end
    if (mif.imem_req_valid === 1'b1) begin
      total++;
      if (mif.imem_addr !== exp_fetch || pc4 !== exp_fetch + 32'd4) begin
        bad++; $display("FAIL addr: got addr=%h pc4=%h want addr=%h", mif.imem_addr, pc4, exp_fetch);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; target = 32'h0; mif.imem_req_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (mif.imem_req_valid !== 1'b1) begin bad++; $display("FAIL rst_req_valid: got %0b want 1", mif.imem_req_valid); end
    total++; if (mif.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", mif.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", if_id_valid); end
    total++; if (if_id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr: got %h want 13", if_id_instr); end
    total++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h/%h want 0/0", if_id_pc, if_id_pc4); end
  endtask

  task automatic test_sequential();
    directed = 1'b1; lat_rand = 1'b0; mem_lat = 0; mif.imem_req_ready = 1'b1;
    tick(); tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h11) begin
      bad++; $display("FAIL seq0: got %0b/%h/%h want 1/0/11", if_id_valid, if_id_pc, if_id_instr); end
    total++; if (mif.imem_addr !== 32'h4) begin bad++; $display("FAIL seq_addr4: got %h want 4", mif.imem_addr); end
    tick(); tick();
    total++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'h22) begin
      bad++; $display("FAIL seq1: got %h/%h want 4/22", if_id_pc, if_id_instr); end
    total++; if (mif.imem_addr !== 32'h8) begin bad++; $display("FAIL seq_addr8: got %h want 8", mif.imem_addr); end
  endtask

  task automatic test_stall();
    tick();
    stall = 1'b1;
    tick();
    total++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'h22 || mif.imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL stall_hold: got %h/%h req=%0b want 4/22 req=0", if_id_pc, if_id_instr, mif.imem_req_valid); end
    tick(); tick();
    stall = 1'b0;
    tick();
    total++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'h33 || if_id_valid !== 1'b1) begin
      bad++; $display("FAIL stall_release: got %h/%h want 8/33", if_id_pc, if_id_instr); end
    total++; if (mif.imem_req_valid !== 1'b1 || mif.imem_addr !== 32'hC) begin
      bad++; $display("FAIL stall_next_addr: got %0b/%h want 1/c", mif.imem_req_valid, mif.imem_addr); end
  endtask

  task automatic test_flush_wait();
    mem_lat = 1;
    tick();
    mem_lat = 0; flush = 1'b1; target = 32'h40;
    tick();
    flush = 1'b0;
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL flushw_valid: got %0b want 0", if_id_valid); end
    tick();
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
      bad++; $display("FAIL flushw_discard: got %0b/%h want 0/13", if_id_valid, if_id_instr); end
    total++; if (mif.imem_req_valid !== 1'b1 || mif.imem_addr !== 32'h40) begin
      bad++; $display("FAIL flushw_redirect: got %0b/%h want 1/40", mif.imem_req_valid, mif.imem_addr); end
    tick(); tick();
    total++; if (if_id_pc !== 32'h40 || if_id_instr !== 32'h121) begin
      bad++; $display("FAIL flushw_deliver: got %h/%h want 40/121", if_id_pc, if_id_instr); end
  endtask

  task automatic test_flush_hold();
    tick();
    stall = 1'b1;
    tick();
    flush = 1'b1; target = 32'h80;
    tick();
    flush = 1'b0;
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
      bad++; $display("FAIL flushh_kill: got %0b/%h want 0/13", if_id_valid, if_id_instr); end
    total++; if (mif.imem_req_valid !== 1'b1 || mif.imem_addr !== 32'h80) begin
      bad++; $display("FAIL flushh_redirect: got %0b/%h want 1/80", mif.imem_req_valid, mif.imem_addr); end
    stall = 1'b0; mif.imem_req_ready = 1'b0;
    tick(); tick();
    total++; if (if_id_valid !== 1'b0 || mif.imem_addr !== 32'h80) begin
      bad++; $display("FAIL flushh_no_buffer: got %0b/%h want 0/80", if_id_valid, mif.imem_addr); end
    mif.imem_req_ready = 1'b1;
  endtask

  task automatic test_random();
    int d0;
    bit ok;
    directed = 1'b0; lat_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      mif.imem_req_ready = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 3);
      // Flush on the cycle a dropped response lands would leave no response to drop.
      ok = !(mem_pend && mem_wait == 0 && pend_q.size() == 0);
      flush = ok && ($urandom_range(0, 15) == 0);
      target = $urandom;
      tick();
    end
    flush = 1'b0; stall = 1'b0; mif.imem_req_ready = 1'b1;
    d0 = delivered;
    repeat (20) tick();
    total++;
    if (delivered - d0 < 2) begin
      bad++; $display("FAIL progress: got %0d deliveries want >=2", delivered - d0);
    end
  endtask

  task automatic test_wrap();
    mif.imem_req_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (wif.imem_req_valid !== 1'b1 || wif.imem_addr !== WRAP_PC) begin
      bad++; $display("FAIL wrap_reset: got %0b/%h want 1/fffffffc", wif.imem_req_valid, wif.imem_addr); end
    total++; if (w_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 0", w_pc4); end
    tick(); tick();
    total++; if (wif.imem_req_valid !== 1'b1 || wif.imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_second_req: got %0b/%h want 1/0", wif.imem_req_valid, wif.imem_addr); end
    total++; if (w_valid !== 1'b1 || w_pc !== WRAP_PC || w_pc_4 !== 32'h0 || w_instr !== 32'h99) begin
      bad++; $display("FAIL wrap_if_id: got %0b/%h/%h/%h want 1/fffffffc/0/99", w_valid, w_pc, w_pc_4, w_instr); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; target = 32'h0;
    mif.imem_req_ready = 1'b0; mif.imem_rsp_valid = 1'b0; mif.imem_rsp_data = 32'h0;
    wif.imem_req_ready = 1'b1; wif.imem_rsp_valid = 1'b1; wif.imem_rsp_data = 32'h99;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_hold();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline. It holds the program counter, issues one instruction-memory request at a time, and loads the IF/ID pipeline register. It consumes the redirect pair `next_pc`/`flush` produced by the next-PC logic and exports `pc4` back to it. On `flush` it redirects the PC, kills the IF/ID entry and discards any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `next_pc`  in  32  PC to load when an instruction is accepted or when a flush occurs.
- `flush`  in  1  redirect request; has priority over `stall`.
- `stall`  in  1  hazard-unit hold; IF/ID keeps its contents while high.
- `pc4`  out  32  current PC + 4, combinational from the PC register.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  fetch address, equal to the current PC.
- `imem_rsp_valid`  in  1  instruction-data strobe.
- `imem_rsp_data`  in  32  instruction word.
- `if_id_valid`  out  1  IF/ID entry is live.
- `if_id_pc`  out  32  PC of the IF/ID instruction.
- `if_id_pc4`  out  32  `if_id_pc` + 4.
- `if_id_instr`  out  32  IF/ID instruction.

## Operation
- The state register has four states: REQ, WAIT, HOLD and DROP.
- **REQ**
  - `imem_req_valid`=1.
  - On `imem_req_ready`=1, go to WAIT.
- **WAIT**
  - Wait for `imem_rsp_valid`.
  - On a response with `stall`=0: write {1, pc, pc+4, data} into IF/ID, set pc<=`next_pc`, and go to REQ.
  - On a response with `stall`=1: latch the word into a one-entry hold buffer and go to HOLD. IF/ID is unchanged.
- **HOLD**
  - No request is issued.
  - When `stall`=0: move the buffer into IF/ID, set pc<=`next_pc`, and go to REQ.
- **DROP**
  - Consume exactly one `imem_rsp_valid` and discard its data, then go to REQ.
- **`next_pc` in normal flow**
  - When `flush`=0, `next_pc` equals `pc4`, so fetch is sequential.
- **Flush, in any state**
  - Set pc<=`next_pc`, `if_id_valid`<=0, `if_id_instr`<=NOP, and clear the hold buffer.
  - Next state from REQ: DROP if the handshake completes in the same cycle, else REQ.
  - Next state from WAIT: DROP, unless `imem_rsp_valid` is high in that cycle, in which case the response is discarded and the next state is REQ.
  - Next state from DROP: stays DROP.
  - Next state from HOLD: REQ.
- **Stall without flush**
  - Every IF/ID field holds.
  - With `stall`=0 and no new instruction, `if_id_valid` stays as written, i.e. it is not cleared.
- **Ignored responses**
  - `imem_rsp_valid` is ignored in REQ and HOLD.
- **Arithmetic**
  - All PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
  - No alignment checks are performed.

## Timing
- **Reset values**
  - state = REQ, pc = `RESET_PC`, `imem_req_valid` = 1 in the first cycle after reset, `imem_addr` = `RESET_PC`.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_pc4`=0, `if_id_instr`=32'h0000_0013 (NOP).
- **Output timing**
  - `imem_req_valid` and `imem_addr` decode from registered state and pc only, with no combinational path from the inputs.
  - `pc4` is combinational from pc.
- **Outstanding requests**
  - At most one request is outstanding.
  - The earliest response is the cycle after the handshake.
- **Throughput and latency**
  - Best-case throughput is one instruction per 2 cycles.
  - IF/ID updates on the edge at the end of the response cycle.
- **Reset mid-operation**
  - Reset returns to REQ with `RESET_PC`.
  - The instruction memory shares `rst`, so no stale response survives reset.

## Structure
- Shared `riscv_pkg` holds:
  - the NOP constant 32'h0000_0013;
  - the fetch state enum {REQ, WAIT, HOLD, DROP};
  - the `RESET_PC` default.
- Sub-module `if_id_reg`: the IF/ID pipeline register with hold and kill controls. It is reusable by later stage registers.

## Test plan
- **Reset:** hold `rst` 2 cycles with `RESET_PC`=0 → `imem_req_valid`=1, `imem_addr`=0, `if_id_valid`=0, `if_id_instr`=32'h13.
- **Sequential fetch:** ready always high; respond to address 0 with 0x11, address 4 with 0x22, address 8 with 0x33, each one cycle after its handshake → IF/ID = (0,0x11), then (4,0x22), then (8,0x33); addresses step 0→4→8→12.
- **Stall:** `stall`=1 during the response for address 8 → IF/ID stays (4,0x22); drop `stall` 3 cycles later → next edge IF/ID = (8,…); the next request address is 12.
- **Flush in WAIT:** `next_pc`=0x40 → `if_id_valid`=0 next cycle; the subsequent response 0xDEAD is discarded; the next request is to 0x40.
- **Flush and stall together while in HOLD:** flush wins → IF/ID killed, the hold buffer is not delivered, and the next request is to `next_pc`.
- **Wrap:** `RESET_PC`=0xFFFF_FFFC → `pc4`=0; the second request is to address 0.
